id_stage_hs: RTL and testbench
==============================

Name: id_stage_hs

Overview:
Handshaked decode stage with an ID/EX pipeline register. It decodes the instruction using control_unit and sign_extend, reads operands from regfile, and registers the results into the EX stage. The generational additions are: valid/ready flow control in both directions, hold on downstream backpressure, load-use hazard bubble insertion, an explicit write-back destination port, and an optional WB-to-ID bypass. The block sits between the IF and EX stages of the pipelined RV32I core.

Parameters:
WIDTH, 32, datapath / register data width
I_ADD_SIZE, 32, instruction and PC width
RF_ADD_SIZE, 5, register-file address width
LOAD_WB_SRC, 3'b001, rf_wb_src encoding that identifies a load

Ports:
i_clk  in  1  clock
i_rstn  in  1  async active-low reset
i_id_valid  in  1  IF holds a valid instruction
o_id_ready  out  1  ID accepts the IF item this cycle (combinational)
i_id_instr  in  I_ADD_SIZE  instruction word
i_id_pc  in  I_ADD_SIZE  PC
i_id_pc_plus4  in  I_ADD_SIZE  PC+4
i_we  in  1  write-back enable
i_wb_dst  in  RF_ADD_SIZE  write-back destination register
i_iwb_data  in  WIDTH  write-back data
i_ie_flush  in  1  squash the ID/EX contents
o_ie_valid  out  1  EX register holds a valid instruction
i_ie_ready  in  1  EX consumes the register this cycle
o_ie_ctrl  out  13  {branch[12], jump[11], alu_op_src[10], alu_ctrl[9:6], rf_we[5], rf_wb_src[4:2], bu_jb[1], mem_we[0]}
o_ie_rf_src_0, o_ie_rf_src_1  out  WIDTH  operand data
o_ie_sx_data  out  WIDTH  sign-extended immediate
o_ie_pc, o_ie_pc_plus4  out  I_ADD_SIZE  forwarded PCs
o_ie_src_0, o_ie_src_1, o_ie_dst  out  RF_ADD_SIZE  rs1, rs2, rd
o_hazard  out  1  load-use stall active (combinational)

Behaviour:
- Reset: i_rstn is asynchronous and active-low; the clock is i_clk. While reset is asserted, every registered output is 0 and o_ie_valid is 0. A reset mid-stall discards the held instruction.
- Register-file writes: regfile is written at (i_wb_dst, i_iwb_data) when i_we=1. i_id_instr[11:7] is never used as the write address.
- advance = ~o_ie_valid | i_ie_ready.
- o_hazard = i_id_valid & o_ie_valid & (o_ie_ctrl[4:2]==LOAD_WB_SRC) & (o_ie_dst!=0) & (o_ie_dst==instr[19:15] | o_ie_dst==instr[24:20]).
- o_id_ready = i_ie_flush | (advance & ~o_hazard).
- Clock-edge priority, highest first:
  1. i_ie_flush: all outputs go to 0 and o_ie_valid to 0. The ID item is discarded, regardless of i_ie_ready.
  2. ~advance: hold all registers unchanged.
  3. o_hazard: load a bubble (all zero, valid 0). The ID instruction stays at IF/ID and is re-decoded the next cycle; one stall cycle per load-use pair.
  4. Otherwise: load the decoded fields, with o_ie_valid=i_id_valid. When i_id_valid=0, load zeros.
- Latency: 1 cycle from an accepted ID item to o_ie_valid.
- Throughput: 1 per cycle when there is no hazard and no backpressure.
- x0 never triggers a hazard. The rs fields are compared even for formats that do not use them; a false stall is acceptable.
- A bubble never asserts rf_we or mem_we.

Optional Feature:
ID_WB_BYPASS_EN:
- Defined: for each source, if i_we & i_wb_dst!=0 & i_wb_dst==rs, the registered operand takes i_iwb_data instead of the regfile read. The same-cycle write is therefore visible to the decode.
- Undefined: operands come straight from regfile. Same-cycle WB/ID overlap returns the regfile's native read value, and a hazard unit must cover that case externally.

Test Plan:
- Reset: assert i_rstn=0 mid-stream -> all outputs 0 and o_ie_valid=0 immediately; after release, the first valid instruction appears after 1 cycle.
- Streaming: addi x1,x0,5 (0x00500093) then add x2,x1,x1 with i_ie_ready=1 -> back-to-back o_ie_valid. o_ie_sx_data=5, o_ie_dst=1 then 2, o_ie_src_0=o_ie_src_1=1.
- Backpressure: i_ie_ready=0 for 3 cycles while EX holds add -> outputs are stable and o_id_ready=0; on release, the next instruction loads 1 cycle later.
- Load-use: lw x5,0(x0) in EX, add x6,x5,x0 in ID -> o_hazard=1, o_id_ready=0, one bubble (valid 0, ctrl 0); add issues the following cycle. Repeat with rd=x0 -> no stall.
- Flush: i_ie_flush=1 with i_ie_ready=0 and a valid EX entry -> next edge o_ie_valid=0, o_ie_ctrl=0, o_id_ready=1.
- Bypass (with ID_WB_BYPASS_EN): i_we=1, i_wb_dst=3, i_iwb_data=0xDEADBEEF, same cycle as ID add x4,x3,x3 -> o_ie_rf_src_0=o_ie_rf_src_1=0xDEADBEEF. Same stimulus with i_wb_dst=0 -> no bypass.

Source files
------------

// File: rtl/id_stage_hs.sv
// Handshaked RV32I decode stage with ID/EX register, load-use bubble insertion and backpressure hold.
// Optional WB-to-ID operand bypass is enabled by defining ID_WB_BYPASS_EN.
module id_stage_hs #(
    parameter int          WIDTH       = 32,
    parameter int          I_ADD_SIZE  = 32,
    parameter int          RF_ADD_SIZE = 5,
    parameter logic [2:0]  LOAD_WB_SRC = 3'b001
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_id_valid,
    output logic                   o_id_ready,
    input  logic [I_ADD_SIZE-1:0]  i_id_instr,
    input  logic [I_ADD_SIZE-1:0]  i_id_pc,
    input  logic [I_ADD_SIZE-1:0]  i_id_pc_plus4,
    input  logic                   i_we,
    input  logic [RF_ADD_SIZE-1:0] i_wb_dst,
    input  logic [WIDTH-1:0]       i_iwb_data,
    input  logic                   i_ie_flush,
    output logic                   o_ie_valid,
    input  logic                   i_ie_ready,
    output logic [12:0]            o_ie_ctrl,
    output logic [WIDTH-1:0]       o_ie_rf_src_0,
    output logic [WIDTH-1:0]       o_ie_rf_src_1,
    output logic [WIDTH-1:0]       o_ie_sx_data,
    output logic [I_ADD_SIZE-1:0]  o_ie_pc,
    output logic [I_ADD_SIZE-1:0]  o_ie_pc_plus4,
    output logic [RF_ADD_SIZE-1:0] o_ie_src_0,
    output logic [RF_ADD_SIZE-1:0] o_ie_src_1,
    output logic [RF_ADD_SIZE-1:0] o_ie_dst,
    output logic                   o_hazard
);

    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic [RF_ADD_SIZE-1:0] rs0, rs1, rd;
    logic                   branch, jump, alu_op_src, rf_we, bu_jb, mem_we;
    logic [3:0]             alu_ctrl;
    logic [2:0]             wb_src;
    logic [31:0]            imm_sel;
    logic [12:0]            ctrl_dec;
    logic [WIDTH-1:0]       sx_dec;

    assign opcode = i_id_instr[6:0];
    assign funct3 = i_id_instr[14:12];
    assign rs0    = RF_ADD_SIZE'(i_id_instr[19:15]);
    assign rs1    = RF_ADD_SIZE'(i_id_instr[24:20]);
    assign rd     = RF_ADD_SIZE'(i_id_instr[11:7]);

    // control_unit and sign_extend
    always_comb begin
        branch     = 1'b0;
        jump       = 1'b0;
        alu_op_src = 1'b0;
        alu_ctrl   = 4'b0000;
        rf_we      = 1'b0;
        wb_src     = 3'b000;
        bu_jb      = 1'b0;
        mem_we     = 1'b0;
        imm_sel    = '0;
        case (opcode)
            7'b0110011: begin
                rf_we    = 1'b1;
                alu_ctrl = {i_id_instr[30], funct3};
            end
            7'b0010011: begin
                alu_op_src = 1'b1;
                rf_we      = 1'b1;
                alu_ctrl   = {(funct3 == 3'b101) & i_id_instr[30], funct3};
                imm_sel    = {{20{i_id_instr[31]}}, i_id_instr[31:20]};
            end
            7'b0000011: begin
                alu_op_src = 1'b1;
                rf_we      = 1'b1;
                wb_src     = LOAD_WB_SRC;
                imm_sel    = {{20{i_id_instr[31]}}, i_id_instr[31:20]};
            end
            7'b0100011: begin
                alu_op_src = 1'b1;
                mem_we     = 1'b1;
                imm_sel    = {{20{i_id_instr[31]}}, i_id_instr[31:25], i_id_instr[11:7]};
            end
            7'b1100011: begin
                branch   = 1'b1;
                alu_ctrl = 4'b1000;
                imm_sel  = {{19{i_id_instr[31]}}, i_id_instr[31], i_id_instr[7],
                            i_id_instr[30:25], i_id_instr[11:8], 1'b0};
            end
            7'b1101111: begin
                jump    = 1'b1;
                rf_we   = 1'b1;
                wb_src  = 3'b010;
                imm_sel = {{11{i_id_instr[31]}}, i_id_instr[31], i_id_instr[19:12],
                           i_id_instr[20], i_id_instr[30:21], 1'b0};
            end
            7'b1100111: begin
                jump       = 1'b1;
                alu_op_src = 1'b1;
                rf_we      = 1'b1;
                wb_src     = 3'b010;
                bu_jb      = 1'b1;
                imm_sel    = {{20{i_id_instr[31]}}, i_id_instr[31:20]};
            end
            7'b0110111: begin
                alu_op_src = 1'b1;
                rf_we      = 1'b1;
                wb_src     = 3'b011;
                imm_sel    = {i_id_instr[31:12], 12'b0};
            end
            7'b0010111: begin
                rf_we   = 1'b1;
                wb_src  = 3'b100;
                imm_sel = {i_id_instr[31:12], 12'b0};
            end
            default: ;
        endcase
    end

    assign ctrl_dec = {branch, jump, alu_op_src, alu_ctrl, rf_we, wb_src, bu_jb, mem_we};
    assign sx_dec   = WIDTH'(signed'(imm_sel));

    // regfile: x0 is never written, so reads of x0 return zero
    logic [WIDTH-1:0] rf_q [2**RF_ADD_SIZE];
    logic [WIDTH-1:0] rd_0, rd_1, op_0, op_1;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < 2**RF_ADD_SIZE; i++) rf_q[i] <= '0;
        end else if (i_we && (i_wb_dst != '0)) begin
            rf_q[i_wb_dst] <= i_iwb_data;
        end
    end

    assign rd_0 = rf_q[rs0];
    assign rd_1 = rf_q[rs1];

`ifdef ID_WB_BYPASS_EN
    assign op_0 = (i_we && (i_wb_dst != '0) && (i_wb_dst == rs0)) ? i_iwb_data : rd_0;
    assign op_1 = (i_we && (i_wb_dst != '0) && (i_wb_dst == rs1)) ? i_iwb_data : rd_1;
`else
    assign op_0 = rd_0;
    assign op_1 = rd_1;
`endif

    // ID/EX register
    logic                   valid_q, valid_d;
    logic [12:0]            ctrl_q, ctrl_d;
    logic [WIDTH-1:0]       op0_q, op0_d, op1_q, op1_d, sx_q, sx_d;
    logic [I_ADD_SIZE-1:0]  pc_q, pc_d, pc4_q, pc4_d;
    logic [RF_ADD_SIZE-1:0] src0_q, src0_d, src1_q, src1_d, dst_q, dst_d;
    logic                   advance, hazard;

    assign advance = ~valid_q | i_ie_ready;
    assign hazard  = i_id_valid & valid_q & (ctrl_q[4:2] == LOAD_WB_SRC) & (dst_q != '0)
                   & ((dst_q == rs0) | (dst_q == rs1));

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        op0_d   = op0_q;
        op1_d   = op1_q;
        sx_d    = sx_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        src0_d  = src0_q;
        src1_d  = src1_q;
        dst_d   = dst_q;
        // flush, bubble and empty slot all collapse to an all-zero entry
        if (i_ie_flush || (advance && (hazard || !i_id_valid))) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            op0_d   = '0;
            op1_d   = '0;
            sx_d    = '0;
            pc_d    = '0;
            pc4_d   = '0;
            src0_d  = '0;
            src1_d  = '0;
            dst_d   = '0;
        end else if (advance) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_dec;
            op0_d   = op_0;
            op1_d   = op_1;
            sx_d    = sx_dec;
            pc_d    = i_id_pc;
            pc4_d   = i_id_pc_plus4;
            src0_d  = rs0;
            src1_d  = rs1;
            dst_d   = rd;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            op0_q   <= '0;
            op1_q   <= '0;
            sx_q    <= '0;
            pc_q    <= '0;
            pc4_q   <= '0;
            src0_q  <= '0;
            src1_q  <= '0;
            dst_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            op0_q   <= op0_d;
            op1_q   <= op1_d;
            sx_q    <= sx_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            src0_q  <= src0_d;
            src1_q  <= src1_d;
            dst_q   <= dst_d;
        end
    end

    assign o_id_ready    = i_ie_flush | (advance & ~hazard);
    assign o_hazard      = hazard;
    assign o_ie_valid    = valid_q;
    assign o_ie_ctrl     = ctrl_q;
    assign o_ie_rf_src_0 = op0_q;
    assign o_ie_rf_src_1 = op1_q;
    assign o_ie_sx_data  = sx_q;
    assign o_ie_pc       = pc_q;
    assign o_ie_pc_plus4 = pc4_q;
    assign o_ie_src_0    = src0_q;
    assign o_ie_src_1    = src1_q;
    assign o_ie_dst      = dst_q;

endmodule

// File: tb/tb_id_stage_hs.sv
// Directed bench for id_stage_hs: flow/hazard/flush model checked every cycle plus literal spot checks.
module tb_id_stage_hs;

    logic        i_clk = 1'b0;
    logic        i_rstn, i_id_valid, o_id_ready, i_we, i_ie_flush, o_ie_valid, i_ie_ready, o_hazard;
    logic [31:0] i_id_instr, i_id_pc, i_id_pc_plus4, i_iwb_data;
    logic [4:0]  i_wb_dst, o_ie_src_0, o_ie_src_1, o_ie_dst;
    logic [12:0] o_ie_ctrl;
    logic [31:0] o_ie_rf_src_0, o_ie_rf_src_1, o_ie_sx_data, o_ie_pc, o_ie_pc_plus4;

    id_stage_hs dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_id_valid(i_id_valid), .o_id_ready(o_id_ready),
        .i_id_instr(i_id_instr), .i_id_pc(i_id_pc), .i_id_pc_plus4(i_id_pc_plus4),
        .i_we(i_we), .i_wb_dst(i_wb_dst), .i_iwb_data(i_iwb_data), .i_ie_flush(i_ie_flush),
        .o_ie_valid(o_ie_valid), .i_ie_ready(i_ie_ready), .o_ie_ctrl(o_ie_ctrl),
        .o_ie_rf_src_0(o_ie_rf_src_0), .o_ie_rf_src_1(o_ie_rf_src_1), .o_ie_sx_data(o_ie_sx_data),
        .o_ie_pc(o_ie_pc), .o_ie_pc_plus4(o_ie_pc_plus4), .o_ie_src_0(o_ie_src_0),
        .o_ie_src_1(o_ie_src_1), .o_ie_dst(o_ie_dst), .o_hazard(o_hazard)
    );

    always #5 i_clk = ~i_clk;

    // Instruction words with hand-decoded control word and immediate
    localparam logic [31:0] ADDI  = 32'h00500093, ADDI_C = 32'h420, ADDI_I = 32'h5;        // addi x1,x0,5
    localparam logic [31:0] ADD2  = 32'h00108133, ADD2_C = 32'h020;                        // add x2,x1,x1
    localparam logic [31:0] SUB7  = 32'h401103B3, SUB7_C = 32'h220;                        // sub x7,x2,x1
    localparam logic [31:0] SW    = 32'h0020A423, SW_C   = 32'h401, SW_I = 32'h8;          // sw x2,8(x1)
    localparam logic [31:0] BEQ   = 32'hFE208EE3, BEQ_C  = 32'h1200, BEQ_I = 32'hFFFFFFFC; // beq x1,x2,-4
    localparam logic [31:0] JAL   = 32'h010000EF, JAL_C  = 32'h828, JAL_I = 32'h10;        // jal x1,16
    localparam logic [31:0] LUI   = 32'h123452B7, LUI_C  = 32'h42C, LUI_I = 32'h12345000;  // lui x5,0x12345
    localparam logic [31:0] LW5   = 32'h00002283, LW0 = 32'h00002003, LW_C = 32'h424;      // lw x5 / lw x0
    localparam logic [31:0] ADD6  = 32'h00028333;                                          // add x6,x5,x0
    localparam logic [31:0] ADD60 = 32'h00000333;                                          // add x6,x0,x0
    localparam logic [31:0] ADD4  = 32'h00318233;                                          // add x4,x3,x3

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] id_ctrl, id_imm;

    // Expected EX register contents
    logic        m_valid = 1'b0;
    logic [31:0] m_ctrl = '0, m_op0 = '0, m_op1 = '0, m_sx = '0, m_pc = '0, m_pc4 = '0;
    logic [31:0] m_s0 = '0, m_s1 = '0, m_dst = '0;
    logic [31:0] m_rf [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_clear();
        m_valid = 1'b0;
        m_ctrl = '0; m_op0 = '0; m_op1 = '0; m_sx = '0; m_pc = '0; m_pc4 = '0;
        m_s0 = '0; m_s1 = '0; m_dst = '0;
    endtask

    function automatic logic m_hazard();
        logic [31:0] a, b;
        a = 32'(i_id_instr[19:15]);
        b = 32'(i_id_instr[24:20]);
        return i_id_valid && m_valid && (m_ctrl[4:2] == 3'b001) && (m_dst != 0)
               && ((m_dst == a) || (m_dst == b));
    endfunction

    function automatic logic [31:0] m_operand(input logic [4:0] rs);
`ifdef ID_WB_BYPASS_EN
        if (i_we && (i_wb_dst != 0) && (i_wb_dst == rs)) return i_iwb_data;
`endif
        return m_rf[rs];
    endfunction

    always @(negedge i_rstn) begin
        m_clear();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
    end

    always @(posedge i_clk) begin : model
        logic adv, haz;
        logic [31:0] n0, n1;
        if (i_rstn) begin
            adv = !m_valid || i_ie_ready;
            haz = m_hazard();
            n0  = m_operand(i_id_instr[19:15]);
            n1  = m_operand(i_id_instr[24:20]);
            if (i_ie_flush) m_clear();
            else if (!adv) ;
            else if (haz) m_clear();
            else if (i_id_valid) begin
                m_valid = 1'b1;
                m_ctrl  = id_ctrl;
                m_sx    = id_imm;
                m_pc    = i_id_pc;
                m_pc4   = i_id_pc_plus4;
                m_s0    = 32'(i_id_instr[19:15]);
                m_s1    = 32'(i_id_instr[24:20]);
                m_dst   = 32'(i_id_instr[11:7]);
                m_op0   = n0;
                m_op1   = n1;
            end else m_clear();
            if (i_we && (i_wb_dst != 0)) m_rf[i_wb_dst] = i_iwb_data;
        end
    end

    always @(negedge i_clk) begin
        #2;
        chk("ie_valid", 32'(o_ie_valid), 32'(m_valid));
        chk("ie_ctrl", 32'(o_ie_ctrl), m_ctrl);
        chk("rf_src_0", o_ie_rf_src_0, m_op0);
        chk("rf_src_1", o_ie_rf_src_1, m_op1);
        chk("sx_data", o_ie_sx_data, m_sx);
        chk("ie_pc", o_ie_pc, m_pc);
        chk("ie_pc4", o_ie_pc_plus4, m_pc4);
        chk("ie_src_0", 32'(o_ie_src_0), m_s0);
        chk("ie_src_1", 32'(o_ie_src_1), m_s1);
        chk("ie_dst", 32'(o_ie_dst), m_dst);
        chk("hazard", 32'(o_hazard), 32'(m_hazard()));
        chk("id_ready", 32'(o_id_ready),
            32'(i_ie_flush || ((!m_valid || i_ie_ready) && !m_hazard())));
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] c,
                         input logic [31:0] imm, input logic [31:0] pc);
        @(negedge i_clk);
        #1;
        i_id_valid    = v;
        i_id_instr    = ins;
        id_ctrl       = c;
        id_imm        = imm;
        i_id_pc       = pc;
        i_id_pc_plus4 = pc + 32'd4;
    endtask

    task automatic wb(input logic we, input logic [4:0] dst, input logic [31:0] data);
        i_we = we; i_wb_dst = dst; i_iwb_data = data;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        i_rstn = 1'b0; i_id_valid = 1'b0; i_id_instr = '0; i_id_pc = '0; i_id_pc_plus4 = '0;
        i_ie_flush = 1'b0; i_ie_ready = 1'b1; id_ctrl = '0; id_imm = '0;
        wb(1'b0, 5'd0, 32'd0);
        @(negedge i_clk); #3;
        chk("rst_valid", 32'(o_ie_valid), 32'd0);
        chk("rst_ctrl", 32'(o_ie_ctrl), 32'd0);

        drive(0, 32'd0, 32'd0, 32'd0, 32'd0); i_rstn = 1'b1; wb(1, 5'd1, 32'h11);
        drive(0, 32'd0, 32'd0, 32'd0, 32'd0); wb(1, 5'd2, 32'h22);
        drive(0, 32'd0, 32'd0, 32'd0, 32'd0); wb(1, 5'd3, 32'h33);
        drive(0, 32'd0, 32'd0, 32'd0, 32'd0); wb(1, 5'd5, 32'h55);
        drive(0, 32'd0, 32'd0, 32'd0, 32'd0); wb(0, 5'd0, 32'd0);

        // streaming
        drive(1, ADDI, ADDI_C, ADDI_I, 32'h100);
        drive(1, ADD2, ADD2_C, 32'd0, 32'h104); #2;
        chk("addi_valid", 32'(o_ie_valid), 32'd1);
        chk("addi_sx", o_ie_sx_data, 32'd5);
        chk("addi_dst", 32'(o_ie_dst), 32'd1);
        chk("addi_ctrl", 32'(o_ie_ctrl), 32'h420);

        // backpressure for three cycles while add sits in EX
        for (int k = 0; k < 3; k++) begin
            drive(1, SUB7, SUB7_C, 32'd0, 32'h108); i_ie_ready = 1'b0; #2;
            chk("bp_valid", 32'(o_ie_valid), 32'd1);
            chk("bp_dst", 32'(o_ie_dst), 32'd2);
            chk("bp_src", {o_ie_src_0, o_ie_src_1}, 32'h21);
            chk("bp_rdy", 32'(o_id_ready), 32'd0);
        end
        drive(1, SUB7, SUB7_C, 32'd0, 32'h108); i_ie_ready = 1'b1; #2;
        chk("bp_rel_rdy", 32'(o_id_ready), 32'd1);
        chk("add_op0", o_ie_rf_src_0, 32'h11);
        drive(1, SW, SW_C, SW_I, 32'h10C); #2;
        chk("sub_dst", 32'(o_ie_dst), 32'd7);
        chk("sub_ctrl", 32'(o_ie_ctrl), 32'h220);
        chk("sub_op0", o_ie_rf_src_0, 32'h22);
        drive(1, BEQ, BEQ_C, BEQ_I, 32'h110); #2;
        chk("sw_ctrl", 32'(o_ie_ctrl), 32'h401);
        chk("sw_sx", o_ie_sx_data, 32'd8);
        drive(1, JAL, JAL_C, JAL_I, 32'h114); #2;
        chk("beq_sx", o_ie_sx_data, 32'hFFFFFFFC);
        drive(1, LUI, LUI_C, LUI_I, 32'h118); #2;
        chk("jal_ctrl", 32'(o_ie_ctrl), 32'h828);
        chk("jal_pc4", o_ie_pc_plus4, 32'h118);

        // load-use
        drive(1, LW5, LW_C, 32'd0, 32'h11C); #2;
        chk("lui_sx", o_ie_sx_data, 32'h12345000);
        drive(1, ADD6, ADD2_C, 32'd0, 32'h120); #2;
        chk("lu_hazard", 32'(o_hazard), 32'd1);
        chk("lu_rdy", 32'(o_id_ready), 32'd0);
        drive(1, ADD6, ADD2_C, 32'd0, 32'h120); #2;
        chk("bubble_valid", 32'(o_ie_valid), 32'd0);
        chk("bubble_ctrl", 32'(o_ie_ctrl), 32'd0);
        chk("bubble_rdy", 32'(o_id_ready), 32'd1);
        drive(1, LW0, LW_C, 32'd0, 32'h124); #2;
        chk("lu_issue_dst", 32'(o_ie_dst), 32'd6);
        chk("lu_issue_op0", o_ie_rf_src_0, 32'h55);
        drive(1, ADD60, ADD2_C, 32'd0, 32'h128); #2;
        chk("x0_hazard", 32'(o_hazard), 32'd0);

        // flush while EX is stalled
        drive(1, SUB7, SUB7_C, 32'd0, 32'h12C); i_ie_ready = 1'b0; i_ie_flush = 1'b1; #2;
        chk("fl_rdy", 32'(o_id_ready), 32'd1);
        chk("fl_pre_valid", 32'(o_ie_valid), 32'd1);
        drive(0, 32'd0, 32'd0, 32'd0, 32'd0); i_ie_ready = 1'b1; i_ie_flush = 1'b0; #2;
        chk("fl_valid", 32'(o_ie_valid), 32'd0);
        chk("fl_ctrl", 32'(o_ie_ctrl), 32'd0);

        // same-cycle write-back vs decode
        drive(1, ADD4, ADD2_C, 32'd0, 32'h130); wb(1, 5'd3, 32'hDEADBEEF);
        drive(1, ADD4, ADD2_C, 32'd0, 32'h134); wb(1, 5'd0, 32'h12345678); #2;
`ifdef ID_WB_BYPASS_EN
        chk("byp_op0", o_ie_rf_src_0, 32'hDEADBEEF);
        chk("byp_op1", o_ie_rf_src_1, 32'hDEADBEEF);
`else
        chk("nobyp_op0", o_ie_rf_src_0, 32'h33);
        chk("nobyp_op1", o_ie_rf_src_1, 32'h33);
`endif
        drive(0, 32'd0, 32'd0, 32'd0, 32'd0); wb(0, 5'd0, 32'd0); #2;
        chk("wb0_op0", o_ie_rf_src_0, 32'hDEADBEEF);
        chk("wb0_op1", o_ie_rf_src_1, 32'hDEADBEEF);

        // reset in the middle of a stall
        drive(1, LW5, LW_C, 32'd0, 32'h138);
        drive(1, ADD6, ADD2_C, 32'd0, 32'h13C); i_ie_ready = 1'b0; #2;
        chk("st_valid", 32'(o_ie_valid), 32'd1);
        i_rstn = 1'b0; #1;
        chk("mrst_valid", 32'(o_ie_valid), 32'd0);
        chk("mrst_ctrl", 32'(o_ie_ctrl), 32'd0);
        chk("mrst_dst", 32'(o_ie_dst), 32'd0);
        chk("mrst_pc", o_ie_pc, 32'd0);
        drive(0, 32'd0, 32'd0, 32'd0, 32'd0); i_rstn = 1'b1; i_ie_ready = 1'b1;
        drive(1, ADDI, ADDI_C, ADDI_I, 32'h200);
        drive(0, 32'd0, 32'd0, 32'd0, 32'd0); #2;
        chk("post_rst_valid", 32'(o_ie_valid), 32'd1);
        chk("post_rst_sx", o_ie_sx_data, 32'd5);
        chk("post_rst_pc", o_ie_pc, 32'h200);
        drive(0, 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge i_clk); #4;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
